board_input_conditioner: RTL

Synthesizable conditioning stage between the DE10-Nano board pins (KEY, SW) and the PULPino Qsys system. Provides parametrised debouncing for any number of push-buttons and slide switches, a reset sequencer driven by KEY[0] that holds the core in reset for a programmable time and then raises fetch enable, and a maskable key-press event register that raises one interrupt line toward the core.

---
 rtl/board_input_conditioner.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/board_input_conditioner.sv
// DE10-Nano KEY/SW conditioning: per-pin debounce, KEY[0]-driven core reset sequencer, key-press IRQ.
// Define BOARD_IO_IRQ_EN to build the press-event register and irq output; otherwise they are tied to 0.

module board_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit IDLE            = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q;
      else                                   cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= IDLE;
      sync2_q  <= IDLE;
      stable_q <= IDLE;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
endmodule

module board_input_conditioner #(
  parameter int NUM_KEYS          = 4,
  parameter int NUM_SW            = 10,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int RESET_HOLD_CYCLES = 350
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n_in,
  input  logic [NUM_SW-1:0]   sw_in,
  output logic [NUM_KEYS-1:0] key_db,
  output logic [NUM_SW-1:0]   sw_db,
  output logic                core_rst_n,
  output logic                fetch_enable,
  input  logic [NUM_KEYS-1:0] irq_mask,
  input  logic [NUM_KEYS-1:0] irq_ack,
  output logic [NUM_KEYS-1:0] irq_pending,
  output logic                irq
);
  localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

  logic [NUM_KEYS-1:0] key_stable;

  // Keys idle high (released), switches idle low.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    board_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(1'b1)) u_db (
      .clk(clk), .reset(reset), .raw_i(key_n_in[i]), .stable_o(key_stable[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    board_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(1'b0)) u_db (
      .clk(clk), .reset(reset), .raw_i(sw_in[i]), .stable_o(sw_db[i])
    );
  end

  assign key_db = ~key_stable;

  typedef enum logic [1:0] {RST_ASSERT, RST_HOLD, RUN} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          run_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      RST_ASSERT: if (!key_db[0]) begin
        state_d = RST_HOLD;
        hold_d  = '0;
      end
      RST_HOLD: begin
        if (key_db[0])                                state_d = RST_ASSERT;
        else if (hold_q == HW'(RESET_HOLD_CYCLES - 1)) state_d = RUN;
        else                                          hold_d  = hold_q + HW'(1);
      end
      RUN:      if (key_db[0]) state_d = RST_ASSERT;
      default:  state_d = RST_ASSERT;
    endcase
  end

  // Outputs come straight from a flop so the core reset never sees decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_ASSERT;
      hold_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      run_q   <= (state_d == RUN);
    end
  end

  assign core_rst_n   = run_q;
  assign fetch_enable = run_q;

`ifdef BOARD_IO_IRQ_EN
  logic [NUM_KEYS-1:0] key_prev_q;
  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic                irq_q;

  // A press landing in the same cycle as its ack wins, so no event is lost.
  always_comb begin
    pend_d    = (pend_q & ~irq_ack) | (key_db & ~key_prev_q);
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_prev_q <= '0;
      pend_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      key_prev_q <= key_db;
      pend_q     <= pend_d;
      irq_q      <= |(pend_q & irq_mask);
    end
  end

  assign irq_pending = pend_q;
  assign irq         = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_mask, irq_ack};
  assign irq_pending       = '0;
  assign irq               = 1'b0;
`endif
endmodule
